div_seq: RTL and testbench

Sequential unsigned integer divider built on repeated subtraction with carry-out as no-borrow, the same add/sub arithmetic the basic ALU uses. It implements the multi-cycle UDIV path next to the single-cycle ALU: a controller starts a division, the block retires one quotient bit per cycle, and then it reports quotient, remainder and a divide-by-zero flag. It handles one operation at a time with a start/busy/done handshake.

---
 rtl/div_seq.sv | 137 +++++++++++++
 tb/tb_div_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: sequential unsigned restoring divider, one quotient bit per clock.
//
// Ports
//   i_clk          clock, rising-edge
//   i_rst          asynchronous active-high reset
//   i_start        request; taken when not in RUN
//   i_dividend     N-bit unsigned dividend, captured on accept
//   i_divisor      N-bit unsigned divisor, captured on accept
//   o_busy         high while iterating
//   o_done         one-cycle completion pulse
//   o_quotient     registered quotient (0 on divide-by-zero)
//   o_remainder    registered remainder (dividend on divide-by-zero)
//   o_div_by_zero  registered flag for the last accepted divisor
//
// State | meaning
// ------+------------------------------------------
// IDLE  | waiting for a request
// RUN   | iterating, one quotient bit per cycle
// DONE  | results just completed, o_done high
module div_seq #(
  parameter int N = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_div_by_zero
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    p_q, p_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  d_q, d_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    t_w;
  logic [N:0]    s_w;
  logic          c_w;
  logic          accept_w;

  // Shift the next dividend bit into the partial remainder. The partial
  // remainder is always below the divisor, so P[N] is zero and the
  // truncation only discards that known-zero bit.
  assign t_w = (N+1)'({p_q, q_q[N-1]});

  // Trial subtract as add-with-complement; carry-out set means T >= D.
  assign {c_w, s_w} = {1'b0, t_w} + {1'b0, ~{1'b0, d_q}} + (N+2)'(1);

  assign accept_w = i_start && (state_q != S_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_RUN: begin
        p_d   = c_w ? s_w : t_w;
        q_d   = {q_q[N-2:0], c_w};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          quot_d  = q_d;
          rem_d   = p_d[N-1:0];
        end
      end
      default: begin
        // IDLE and DONE share the accept path; DONE otherwise falls to IDLE.
        state_d = S_IDLE;
        if (accept_w) begin
          d_d   = i_divisor;
          q_d   = i_dividend;
          p_d   = '0;
          cnt_d = '0;
          if (i_divisor == '0) begin
            state_d = S_DONE;
            quot_d  = '0;
            rem_d   = i_dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            dbz_d   = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign o_busy        = (state_q == S_RUN);
  assign o_done        = (state_q == S_DONE);
  assign o_quotient    = quot_q;
  assign o_remainder   = rem_q;
  assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: an N=8 instance for directed cases and an N=64
// instance for the regression. A cycle-level model computes expected
// results with plain / and %, and a negedge process compares every cycle.
module tb_div_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start[2];
  logic [63:0] dvd[2];
  logic [63:0] dvs[2];

  logic        busy8, done8, dbz8, busy64, done64, dbz64;
  logic [7:0]  q8, r8;
  logic [63:0] q64, r64;

  logic        busy_a[2], done_a[2], dbz_a[2];
  logic [63:0] act_q[2], act_r[2];

  assign busy_a[0] = busy8;   assign busy_a[1] = busy64;
  assign done_a[0] = done8;   assign done_a[1] = done64;
  assign dbz_a[0]  = dbz8;    assign dbz_a[1]  = dbz64;
  assign act_q[0]  = {56'b0, q8};  assign act_q[1] = q64;
  assign act_r[0]  = {56'b0, r8};  assign act_r[1] = r64;

  div_seq #(.N(8)) u_div8 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]),
    .i_dividend(dvd[0][7:0]), .i_divisor(dvs[0][7:0]),
    .o_busy(busy8), .o_done(done8), .o_quotient(q8),
    .o_remainder(r8), .o_div_by_zero(dbz8)
  );

  div_seq #(.N(64)) u_div64 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]),
    .i_dividend(dvd[1]), .i_divisor(dvs[1]),
    .o_busy(busy64), .o_done(done64), .o_quotient(q64),
    .o_remainder(r64), .o_div_by_zero(dbz64)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // cyc numbers the cycle that follows each rising edge. An op accepted at
  // edge E completes (o_done high) in cycle E for a zero divisor and in
  // cycle E+N otherwise; it is busy in the cycles before that.
  longint      cyc = 0;
  int          NS[2] = '{8, 64};
  bit          m_active[2];
  longint      m_done[2];
  logic [63:0] m_q[2], m_r[2], m_pq[2], m_pr[2];
  logic        m_dbz[2];
  logic [63:0] ma, mb, mmask;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_active[k] = 1'b0;
        m_done[k]   = 0;
        m_q[k]      = '0;
        m_r[k]      = '0;
        m_dbz[k]    = 1'b0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        mmask = (k == 0) ? 64'hFF : {64{1'b1}};
        if (start[k] && !(m_active[k] && (cyc - 1) < m_done[k])) begin
          ma = dvd[k] & mmask;
          mb = dvs[k] & mmask;
          if (mb == 0) begin
            m_pq[k] = '0;  m_pr[k] = ma;  m_dbz[k] = 1'b1;  m_done[k] = cyc;
          end else begin
            m_pq[k] = ma / mb;  m_pr[k] = ma % mb;  m_dbz[k] = 1'b0;
            m_done[k] = cyc + NS[k];
          end
          m_active[k] = 1'b1;
        end
        if (m_active[k] && m_done[k] == cyc) begin
          m_q[k] = m_pq[k];
          m_r[k] = m_pr[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk(k == 0 ? "busy8" : "busy64", {63'b0, busy_a[k]},
          {63'b0, m_active[k] && (cyc < m_done[k])});
      chk(k == 0 ? "done8" : "done64", {63'b0, done_a[k]},
          {63'b0, m_active[k] && (cyc == m_done[k])});
      chk(k == 0 ? "quot8" : "quot64", act_q[k], m_q[k]);
      chk(k == 0 ? "rem8"  : "rem64",  act_r[k], m_r[k]);
      chk(k == 0 ? "dbz8"  : "dbz64",  {63'b0, dbz_a[k]}, {63'b0, m_dbz[k]});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_done(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_a[k]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout dut%0d: o_done not seen within 200 cycles", k);
    end
  endtask

  // Issues one request and returns at the negedge of its o_done cycle.
  // lat = edges from the accepting edge to the edge that raised o_done.
  task automatic run_op(input int k, input logic [63:0] a, input logic [63:0] b,
                        output longint lat, output bit ok);
    longint t0;
    @(negedge clk);
    start[k] = 1'b1; dvd[k] = a; dvs[k] = b;
    @(negedge clk);
    start[k] = 1'b0; dvd[k] = ~a; dvs[k] = {$urandom, $urandom};
    t0 = cyc;
    wait_done(k, ok);
    lat = cyc - t0;
  endtask

  task automatic dir8(input logic [63:0] a, input logic [63:0] b, input logic [63:0] eq,
                      input logic [63:0] er, input logic ez, input longint elat);
    longint lat;
    bit ok;
    run_op(0, a, b, lat, ok);
    chk($sformatf("%0d/%0d quotient", a, b), act_q[0], eq);
    chk($sformatf("%0d/%0d remainder", a, b), act_r[0], er);
    chk($sformatf("%0d/%0d dbz", a, b), {63'b0, dbz_a[0]}, {63'b0, ez});
    chk($sformatf("%0d/%0d latency", a, b), 64'(lat), 64'(elat));
  endtask

  task automatic op64(input logic [63:0] a, input logic [63:0] b);
    longint lat;
    bit ok;
    logic [127:0] recon;
    run_op(1, a, b, lat, ok);
    if (ok) begin
      if (b != 0) begin
        recon = 128'(act_q[1]) * 128'(b) + 128'(act_r[1]);
        chk("inv_lo", recon[63:0], a);
        chk("inv_hi", recon[127:64], 64'd0);
        chk("rem_lt_div", {63'b0, act_r[1] < b}, 64'd1);
        chk("lat64", 64'(lat), 64'd64);
      end else begin
        chk("lat64_dbz", 64'(lat), 64'd0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint lat;
    longint prev_done;
    bit ok;
    int seen;
    logic [63:0] a, b;

    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; dvd[k] = '0; dvs[k] = '0;
    end

    repeat (2) @(negedge clk);
    chk("reset busy",  {63'b0, busy8}, 64'd0);
    chk("reset done",  {63'b0, done8}, 64'd0);
    chk("reset quot",  {56'b0, q8}, 64'd0);
    chk("reset rem",   {56'b0, r8}, 64'd0);
    chk("reset dbz",   {63'b0, dbz8}, 64'd0);
    rst = 1'b0;

    dir8(100, 7, 14, 2, 1'b0, 8);
    dir8(255, 1, 255, 0, 1'b0, 8);
    dir8(5, 9, 0, 5, 1'b0, 8);
    dir8(255, 255, 1, 0, 1'b0, 8);
    dir8(0, 3, 0, 0, 1'b0, 8);
    dir8(42, 0, 0, 42, 1'b1, 0);
    dir8(9, 3, 3, 0, 1'b0, 8);

    // Start during RUN is ignored; start held in DONE is accepted.
    @(negedge clk);
    start[0] = 1'b1; dvd[0] = 200; dvs[0] = 6;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    start[0] = 1'b1; dvd[0] = 10; dvs[0] = 2;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, ok);
    chk("ignored start quotient", act_q[0], 64'd33);
    chk("ignored start remainder", act_r[0], 64'd2);
    prev_done = cyc;
    start[0] = 1'b1; dvd[0] = 77; dvs[0] = 7;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, ok);
    chk("back-to-back spacing", 64'(cyc - prev_done), 64'd9);
    chk("back-to-back quotient", act_q[0], 64'd11);
    chk("back-to-back remainder", act_r[0], 64'd0);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    start[0] = 1'b1; dvd[0] = 100; dvs[0] = 7;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", {63'b0, busy8}, 64'd0);
    chk("async rst done", {63'b0, done8}, 64'd0);
    chk("async rst quot", {56'b0, q8}, 64'd0);
    chk("async rst rem",  {56'b0, r8}, 64'd0);
    chk("async rst dbz",  {63'b0, dbz8}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) seen++;
    end
    chk("no done after reset", 64'(seen), 64'd0);
    dir8(100, 7, 14, 2, 1'b0, 8);

    // N=64 corner cases with literal expectations.
    run_op(1, {64{1'b1}}, 64'd1, lat, ok);
    chk("max/1 quotient", act_q[1], {64{1'b1}});
    chk("max/1 remainder", act_r[1], 64'd0);
    run_op(1, {64{1'b1}}, 64'h8000_0000_0000_0000, lat, ok);
    chk("max/2^63 quotient", act_q[1], 64'd1);
    chk("max/2^63 remainder", act_r[1], 64'h7FFF_FFFF_FFFF_FFFF);
    chk("max/2^63 latency", 64'(lat), 64'd64);
    run_op(1, 64'd5, 64'h8000_0000_0000_0000, lat, ok);
    chk("5/2^63 quotient", act_q[1], 64'd0);
    chk("5/2^63 remainder", act_r[1], 64'd5);

    op64({64{1'b1}}, {64{1'b1}});
    op64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    op64(64'd12345, 64'd1);
    op64({64{1'b1}}, 64'd0);
    op64(64'd0, 64'd0);
    op64({64{1'b1}}, 64'd3);

    for (int i = 0; i < 400; i++) begin
      a = {$urandom, $urandom} >> $urandom_range(0, 63);
      case ($urandom_range(0, 9))
        0:       b = 64'd1;
        1:       b = 64'h8000_0000_0000_0000;
        2:       b = 64'd0;
        default: b = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      if ($urandom_range(0, 19) == 0) a = {64{1'b1}};
      op64(a, b);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
